// File: rtl/eth_xgmii_tx_encap.sv
// eth_xgmii_tx_encap: wraps an 8-byte frame stream in XGMII /S/+preamble+SFD, /T/, idle fill and IPG.
// A missing or short non-last beat aborts the frame with an /E/ word and the rest of it is dropped.
module eth_xgmii_tx_encap #(
  parameter int N_CHANNELS = 8,
  parameter int W_BYTE     = 8,
  parameter int IPG_BYTES  = 12,
  parameter int W_IPG_CNT  = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clk_en,
  input  logic [N_CHANNELS*W_BYTE-1:0] i_tdata,
  input  logic [N_CHANNELS-1:0]        i_tkeep,
  input  logic                         i_tvalid,
  input  logic                         i_tlast,
  output logic                         o_tready,
  output logic [N_CHANNELS-1:0]        o_xgmii_ctrl,
  output logic [N_CHANNELS*W_BYTE-1:0] o_xgmii_data,
  output logic                         o_underrun
);

  localparam int W_LANE = $clog2(N_CHANNELS + 1);

  localparam logic [W_BYTE-1:0] CH_IDLE  = W_BYTE'(8'h07);
  localparam logic [W_BYTE-1:0] CH_START = W_BYTE'(8'hFB);
  localparam logic [W_BYTE-1:0] CH_PRE   = W_BYTE'(8'h55);
  localparam logic [W_BYTE-1:0] CH_SFD   = W_BYTE'(8'hD5);
  localparam logic [W_BYTE-1:0] CH_TERM  = W_BYTE'(8'hFD);
  localparam logic [W_BYTE-1:0] CH_ERR   = W_BYTE'(8'hFE);

  // ST_IPG with a satisfied gap doubles as the idle state.
  typedef enum logic [1:0] {ST_IPG, ST_DATA, ST_TERM, ST_DROP} state_e;

  state_e                       state_q, state_d;
  logic [W_IPG_CNT-1:0]         ipg_cnt_q, ipg_cnt_d;
  logic [N_CHANNELS-1:0]        ctrl_q, ctrl_d;
  logic [N_CHANNELS*W_BYTE-1:0] data_q, data_d;
  logic                         underrun_q, underrun_d;

  logic [W_LANE-1:0]            keep_n;
  logic [W_IPG_CNT:0]           ipg_sum;
  logic [W_IPG_CNT-1:0]         ipg_inc;
  logic                         ipg_ok;
  logic                         beat_bad;

  // Number of valid lanes = index of the first zero in tkeep, which also tames malformed masks.
  always_comb begin
    keep_n = W_LANE'(N_CHANNELS);
    for (int k = N_CHANNELS - 1; k >= 0; k--) begin
      if (!i_tkeep[k]) keep_n = W_LANE'(k);
    end
  end

  assign ipg_sum  = {1'b0, ipg_cnt_q} + (W_IPG_CNT+1)'(N_CHANNELS);
  assign ipg_inc  = ipg_sum[W_IPG_CNT] ? '1 : ipg_sum[W_IPG_CNT-1:0];
  assign ipg_ok   = ipg_cnt_q >= W_IPG_CNT'(IPG_BYTES);
  assign beat_bad = !i_tvalid || (!i_tlast && (i_tkeep != '1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IPG;
      ipg_cnt_q  <= W_IPG_CNT'(IPG_BYTES);
      ctrl_q     <= '1;
      data_q     <= {N_CHANNELS{CH_IDLE}};
      underrun_q <= 1'b0;
    end else if (i_clk_en) begin
      state_q    <= state_d;
      ipg_cnt_q  <= ipg_cnt_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ipg_cnt_d = ipg_cnt_q;
    unique case (state_q)
      ST_IPG: begin
        if (!ipg_ok) ipg_cnt_d = ipg_inc;
        else if (i_tvalid) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_bad) begin
          state_d = ST_DROP;
        end else if (i_tlast) begin
          if (keep_n == W_LANE'(N_CHANNELS)) begin
            state_d = ST_TERM;
          end else begin
            state_d   = ST_IPG;
            ipg_cnt_d = W_IPG_CNT'(N_CHANNELS) - W_IPG_CNT'(keep_n);
          end
        end
      end
      ST_TERM: begin
        state_d   = ST_IPG;
        ipg_cnt_d = W_IPG_CNT'(N_CHANNELS);
      end
      ST_DROP: begin
        if (i_tvalid && i_tlast) begin
          state_d   = ST_IPG;
          ipg_cnt_d = W_IPG_CNT'(IPG_BYTES);
        end
      end
      default: state_d = ST_IPG;
    endcase
  end

  always_comb begin
    ctrl_d     = '1;
    data_d     = {N_CHANNELS{CH_IDLE}};
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IPG: begin
        if (ipg_ok && i_tvalid) begin
          ctrl_d = N_CHANNELS'(1);
          data_d = {CH_SFD, {(N_CHANNELS-2){CH_PRE}}, CH_START};
        end
      end
      ST_DATA: begin
        if (beat_bad) begin
          data_d     = {N_CHANNELS{CH_ERR}};
          underrun_d = 1'b1;
        end else begin
          // Full beats have keep_n == N_CHANNELS, so this covers both payload and /T/ words.
          for (int k = 0; k < N_CHANNELS; k++) begin
            if (k < int'(keep_n)) begin
              ctrl_d[k]                  = 1'b0;
              data_d[k*W_BYTE +: W_BYTE] = i_tdata[k*W_BYTE +: W_BYTE];
            end else if (k == int'(keep_n)) begin
              data_d[k*W_BYTE +: W_BYTE] = CH_TERM;
            end
          end
        end
      end
      ST_TERM: data_d[W_BYTE-1:0] = CH_TERM;
      ST_DROP: begin
      end
      default: begin
      end
    endcase
  end

  assign o_tready     = i_clk_en && ((state_q == ST_DATA) || (state_q == ST_DROP));
  assign o_xgmii_ctrl = ctrl_q;
  assign o_xgmii_data = data_q;
  assign o_underrun   = underrun_q && i_clk_en;

endmodule

// File: doc/eth_xgmii_tx_encap.md
Name: eth_xgmii_tx_encap

Overview:
- Upstream neighbour of the 10G PCS TX.
- Converts an 8-byte-wide frame stream into XGMII TX characters for the PCS 64/66 encoder.
- Frames arrive with FCS already appended. This block adds /S/ + preamble + SFD, /T/ termination, idle fill, minimum inter-packet gap and underrun error marking.
- Honours the gearbox clock-enable, so no XGMII word is lost during gearbox pause cycles.

Parameters:
N_CHANNELS, 8, XGMII lanes per word.
W_BYTE, 8, bits per lane.
IPG_BYTES, 12, minimum idle characters between frames, counting /T/ and all following idle lanes.
W_IPG_CNT, 5, width of the IPG counter; must hold IPG_BYTES+N_CHANNELS.

Ports:
i_clk  in  1  PCS TX clock.
i_reset  in  1  asynchronous, active-low reset.
i_clk_en  in  1  gearbox clock-enable; all state advances only when 1.
i_tdata  in  N_CHANNELS*W_BYTE  frame bytes; lane k = bits [8k+7:8k]; lane 0 is first on the wire.
i_tkeep  in  N_CHANNELS  byte valid; must be all-ones except on the last beat; contiguous from lane 0.
i_tvalid  in  1  beat valid.
i_tlast  in  1  last beat of frame.
o_tready  out  1  beat accepted when i_tvalid & o_tready.
o_xgmii_ctrl  out  N_CHANNELS  per-lane control flag.
o_xgmii_data  out  N_CHANNELS*W_BYTE  per-lane character.
o_underrun  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (async assert, sync release):
  - state=IPG, ipg_cnt=IPG_BYTES (gap already satisfied).
  - outputs = idle word: ctrl=8'hFF, every lane 8'h07.
  - o_tready=0, o_underrun=0.
- Registered outputs; one-cycle latency from accepted beat to its XGMII word.
- i_clk_en=0:
  - state, counters and outputs hold.
  - o_tready=0 combinationally.
  - o_underrun forced 0.
- o_tready = i_clk_en & (state==DATA | state==DROP).
- States, evaluated only when i_clk_en=1:
  - IDLE:
    - Emit idle word.
    - If i_tvalid, emit start word and go to DATA. Start word: lane0 8'hFB ctrl=1; lanes1-6 8'h55; lane7 8'hD5; ctrl=8'h01.
    - /S/ is only ever placed in lane 0.
  - DATA:
    - i_tvalid=0: emit error word (all lanes 8'hFE, ctrl=FF), pulse o_underrun, go to DROP.
    - Non-last beat with i_tkeep!=FF: same as i_tvalid=0 (error word, o_underrun pulse, DROP). The beat is consumed.
    - Non-last beat with i_tkeep=FF: emit data, ctrl=0.
    - Last beat, n=popcount(tkeep)<8:
      - Lanes <n carry data, ctrl=0.
      - Lane n = 8'hFD, ctrl=1.
      - Lanes >n = 8'h07, ctrl=1.
      - ipg_cnt=8-n; go to IPG.
    - Last beat, n=8: emit data word, go to TERM.
  - TERM: emit lane0 8'hFD, lanes1-7 8'h07, ctrl=FF; ipg_cnt=8; go to IPG.
  - DROP:
    - Emit idle word; consume beats until an accepted beat with i_tlast.
    - Then set ipg_cnt=IPG_BYTES and go to IPG, so the gap is satisfied at once.
  - IPG:
    - If ipg_cnt>=IPG_BYTES, act exactly as IDLE this cycle (start allowed).
    - Otherwise emit idle word and set ipg_cnt=ipg_cnt+8, saturating at its maximum.
- IDLE and IPG(satisfied) are equivalent; the implementation may merge them.
- Malformed tkeep on the last beat (non-contiguous or zero): treated as n = index of the first zero lane. A zero n yields /T/ in lane 0.
- o_underrun asserts only on the cycle the error word is emitted.
- Reset mid-frame: output returns to idle immediately. The remainder of the upstream frame is then sent as a new frame; upstream must flush on reset.

Test Plan:
- 64-byte frame (8 full beats, last tkeep=FF), contiguous valid, i_clk_en=1:
  - Words: start, 8 data, TERM word (FD,07x7).
  - Next start no earlier than 2 cycles after the TERM word (ipg 8 -> 16 >= 12).
- 61-byte frame (last tkeep=8'h1F):
  - Last word has lanes0-4 data, lane5 FD, lanes6-7 07, ctrl=8'hE0.
  - Back-to-back next frame: 2 idle words (3 -> 11 -> 19), then start.
- i_clk_en deasserted 1 cycle in 33 during a 1500-byte frame:
  - o_tready low on those cycles; outputs held.
  - Received byte stream identical to input; no duplicate or missing words.
- i_tvalid dropped for 1 cycle after 3 data beats:
  - One word of all FE, ctrl=FF; o_underrun high exactly 1 cycle.
  - Remaining beats drained with idles until tlast; next frame starts on the next enabled cycle.
- Non-last beat with tkeep=8'h7F: error word and o_underrun pulse, same as the underrun case.
- i_reset low for 1 cycle mid-frame: outputs immediately ctrl=FF / all 07 and o_tready=0; a new frame is accepted right after release.
